// File: rtl/led_pattern_drv.sv
// led_pattern_drv: four-channel LED mode driver.
// Each key_pos[n] pulse steps channel n through OFF -> ON -> BLINK -> (BREATHE) -> OFF.
// The 1 ms tick, blink phase and breathe PWM are shared by all channels and run freely.
// Optional feature macro: LED_BREATHE_EN adds the BREATHE mode with its PWM/duty logic.
// Without it, channels cycle OFF -> ON -> BLINK -> OFF.
module led_pattern_drv #(
   parameter int unsigned CLK_FREQ      = 50_000_000,
   parameter int unsigned BLINK_HALF_MS = 250
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] key_pos,
   output logic [7:0] led,
   output logic [7:0] mode
);

   localparam int unsigned TICK_CYC   = ((CLK_FREQ / 1000) > 0) ? (CLK_FREQ / 1000) : 1;
   localparam int unsigned PW         = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int unsigned HALF       = (BLINK_HALF_MS > 0) ? BLINK_HALF_MS : 1;
   localparam int unsigned BW         = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   // Next mode in the per-channel ring; the ring is shorter without breathe.
   function automatic mode_e next_mode(input mode_e cur);
      mode_e nxt;
      case (cur)
         MODE_OFF:     nxt = MODE_ON;
         MODE_ON:      nxt = MODE_BLINK;
`ifdef LED_BREATHE_EN
         MODE_BLINK:   nxt = MODE_BREATHE;
         MODE_BREATHE: nxt = MODE_OFF;
`else
         MODE_BLINK:   nxt = MODE_OFF;
`endif
         default:      nxt = MODE_OFF;
      endcase
      return nxt;
   endfunction

   logic [PW-1:0] presc_q, presc_d;
   logic          tick_s;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   mode_e         mode_q [4];
   mode_e         mode_d [4];
   logic [7:0]    led_q, led_d;
   logic [3:0]    lit_s;
   logic [3:0]    active_s;

   assign tick_s = (presc_q == PRESC_LAST);

   // Prescaler wraps every TICK_CYC cycles; the tick fires on its last count.
   always_comb begin
      presc_d = presc_q;
      if (tick_s) begin
         presc_d = {PW{1'b0}};
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Shared blink counter: counts ticks, toggles the phase on each wrap.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (tick_s) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = {BW{1'b0}};
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            phase_d     = phase_q;
         end
      end else begin
         blink_cnt_d = blink_cnt_q;
         phase_d     = phase_q;
      end
   end

   // Each addressed channel advances one mode; channels are independent.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         mode_d[n] = mode_q[n];
         if (key_pos[n]) begin
            mode_d[n] = next_mode(mode_q[n]);
         end else begin
            mode_d[n] = mode_q[n];
         end
      end
   end

`ifdef LED_BREATHE_EN
   logic [3:0] pwm_cnt_q, pwm_cnt_d;
   logic [3:0] wrap_cnt_q, wrap_cnt_d;
   logic [3:0] duty_q, duty_d;
   logic       duty_up_q, duty_up_d;

   // Breathe PWM: pwm_cnt steps per tick; duty walks a 0..15..0 triangle every 16 pwm wraps.
   always_comb begin
      pwm_cnt_d  = pwm_cnt_q;
      wrap_cnt_d = wrap_cnt_q;
      duty_d     = duty_q;
      duty_up_d  = duty_up_q;
      if (tick_s) begin
         pwm_cnt_d = pwm_cnt_q + 4'd1;
         if (pwm_cnt_q == 4'd15) begin
            wrap_cnt_d = wrap_cnt_q + 4'd1;
            if (wrap_cnt_q == 4'd15) begin
               if (duty_up_q) begin
                  if (duty_q == 4'd15) begin
                     duty_d    = 4'd14;
                     duty_up_d = 1'b0;
                  end else begin
                     duty_d    = duty_q + 4'd1;
                     duty_up_d = 1'b1;
                  end
               end else begin
                  if (duty_q == 4'd0) begin
                     duty_d    = 4'd1;
                     duty_up_d = 1'b1;
                  end else begin
                     duty_d    = duty_q - 4'd1;
                     duty_up_d = 1'b0;
                  end
               end
            end else begin
               duty_d    = duty_q;
               duty_up_d = duty_up_q;
            end
         end else begin
            wrap_cnt_d = wrap_cnt_q;
         end
      end else begin
         pwm_cnt_d = pwm_cnt_q;
      end
   end

   // Breathe state registers; direction starts upward out of reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pwm_cnt_q  <= 4'd0;
         wrap_cnt_q <= 4'd0;
         duty_q     <= 4'd0;
         duty_up_q  <= 1'b1;
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
         duty_q     <= duty_d;
         duty_up_q  <= duty_up_d;
      end
   end
`endif

   // LED image from the registered modes: low nibble lights, high nibble marks non-OFF.
   always_comb begin
      lit_s    = 4'b0000;
      active_s = 4'b0000;
      for (int n = 0; n < 4; n++) begin
         case (mode_q[n])
            MODE_OFF:     lit_s[n] = 1'b0;
            MODE_ON:      lit_s[n] = 1'b1;
            MODE_BLINK:   lit_s[n] = phase_q;
`ifdef LED_BREATHE_EN
            MODE_BREATHE: lit_s[n] = (pwm_cnt_q < duty_q);
`endif
            default:      lit_s[n] = 1'b0;
         endcase
         active_s[n] = (mode_q[n] != MODE_OFF);
      end
      led_d = {~active_s, ~lit_s};
   end

   // Main state: prescaler, blink phase, channel modes and the registered LED image.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         presc_q     <= {PW{1'b0}};
         blink_cnt_q <= {BW{1'b0}};
         phase_q     <= 1'b0;
         led_q       <= 8'hFF;
         for (int n = 0; n < 4; n++) begin
            mode_q[n] <= MODE_OFF;
         end
      end else begin
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         led_q       <= led_d;
         for (int n = 0; n < 4; n++) begin
            mode_q[n] <= mode_d[n];
         end
      end
   end

   assign led  = led_q;
   assign mode = {mode_q[3], mode_q[2], mode_q[1], mode_q[0]};

endmodule

// File: tb/tb_led_pattern_drv.sv
// Directed self-checking bench for led_pattern_drv (CLK_FREQ=16000, BLINK_HALF_MS=4).
// Blink/breathe expectations are derived from the number of clock edges since reset release.
module tb_led_pattern_drv;

   logic       clk;
   logic       rst_n;
   logic [3:0] key;
   logic [7:0] led;
   logic [7:0] mode;

   int checks = 0;
   int errors = 0;
   int cyc;
   int seen3 = 0;

   led_pattern_drv #(.CLK_FREQ(16000), .BLINK_HALF_MS(4)) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .key_pos  (key),
      .led      (led),
      .mode     (mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge count since reset release (cyc = e just after edge e).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

`ifndef LED_BREATHE_EN
   // Mode code 3 must never appear without breathe support.
   always @(negedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (mode[2*n +: 2] == 2'd3) seen3 <= seen3 + 1;
      end
   end
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [3:0] k);
      key = k;
      step();
      key = 4'b0000;
   endtask

   initial begin
      int k;
      int s;
      int duty;
      int pwm;
      logic [7:0] exp;

      rst_n = 1'b0;
      key   = 4'b0000;
      repeat (3) step();
      chk("rst_led", led, 8'hFF);
      chk("rst_mode", mode, 8'h00);
      rst_n = 1'b1;

      // Idle after reset: nothing lights.
      for (int i = 0; i < 1000; i++) begin
         step();
         chk("idle_led", led, 8'hFF);
         chk("idle_mode", mode, 8'h00);
      end

      // Channel 0 ON: mode after one edge, LED after two.
      pulse(4'b0001);
      chk("on_mode", mode, 8'h01);
      chk("on_led_lat1", led, 8'hFF);
      step();
      chk("on_led", led, 8'hEE);

      // Channels 0 and 1 to BLINK, then check phase-locked blinking.
      pulse(4'b0001);
      chk("blink0_mode", mode, 8'h02);
      pulse(4'b0010);
      chk("on1_mode", mode, 8'h06);
      pulse(4'b0010);
      chk("blink1_mode", mode, 8'h0A);
      step();
      for (int i = 0; i < 200; i++) begin
         step();
         k = cyc - 1;
         exp = (((k / 64) % 2) == 1) ? 8'hCC : 8'hCF;
         chk("blink_led", led, exp);
      end

`ifdef LED_BREATHE_EN
      pulse(4'b0011);
      chk("breathe01_mode", mode, 8'h0F);
      pulse(4'b0011);
`else
      pulse(4'b0011);
`endif
      chk("back_off_mode", mode, 8'h00);
      step();
      chk("back_off_led", led, 8'hFF);

      // All channels together.
      pulse(4'b1111);
      chk("all_on_mode", mode, 8'h55);
      step();
      chk("all_on_led", led, 8'h00);
      pulse(4'b1111);
      chk("all_blink_mode", mode, 8'hAA);
      step();

      // Asynchronous reset mid-operation.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_led", led, 8'hFF);
      chk("async_rst_mode", mode, 8'h00);
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("post_rst_mode", mode, 8'h00);
      chk("post_rst_led", led, 8'hFF);

      // Full ring with all four keys.
      pulse(4'b1111);
      chk("ring_mode1", mode, 8'h55);
      pulse(4'b1111);
      chk("ring_mode2", mode, 8'hAA);
`ifdef LED_BREATHE_EN
      pulse(4'b1111);
      chk("ring_mode3", mode, 8'hFF);
`endif
      pulse(4'b1111);
      chk("ring_mode0", mode, 8'h00);
      step();
      chk("ring_led", led, 8'hFF);

`ifdef LED_BREATHE_EN
      // Channel 2 breathing: led[2] follows pwm < duty triangle.
      pulse(4'b0100);
      chk("br_mode1", mode, 8'h10);
      pulse(4'b0100);
      chk("br_mode2", mode, 8'h20);
      pulse(4'b0100);
      chk("br_mode3", mode, 8'h30);
      step();
      for (int i = 0; i < 75000; i++) begin
         step();
         k    = cyc - 1;
         pwm  = (k / 16) % 16;
         s    = (k / 4096) % 30;
         duty = (s <= 15) ? s : (30 - s);
         exp  = (pwm < duty) ? 8'hBB : 8'hBF;
         chk("breathe_led", led, exp);
      end
`else
      // Channel 3 ring without breathe: 1, 2, 0.
      pulse(4'b1000);
      chk("nb_mode_on", {30'd0, mode[7:6]}, 32'd1);
      pulse(4'b1000);
      chk("nb_mode_blink", {30'd0, mode[7:6]}, 32'd2);
      pulse(4'b1000);
      chk("nb_mode_off", {30'd0, mode[7:6]}, 32'd0);
      step();
      chk("nb_led", led, 8'hFF);
      chk("nb_never3", seen3, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
